pipeline_sequencer: RTL

Central hazard and flow controller for the five-stage core (F, D, E, M, W). Each cycle it combines the decode-stage hazard and prediction requests, execute-stage mispredict, serialization and multi-cycle-busy status, and memory-stage busy into per-stage stall and flush controls plus a fetch redirect select. It holds a small state machine that drains the back end for serializing instructions (FENCE, CSR, EBREAK) and parks the core in a halted state after EBREAK. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/sat_counter.sv | 28 ++
 rtl/pipeline_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer.
//   seqState_t     : sequencer state encoding (RUN/DRAIN/HALT)
//   REDIR_*        : fetch PC select encodings driven on redirect_o
//   drainCntWidth  : width of a down-counter able to hold DRAIN_CYCLES
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } seqState_t;

  localparam logic [1:0] REDIR_SEQ  = 2'b00;
  localparam logic [1:0] REDIR_PRED = 2'b01;
  localparam logic [1:0] REDIR_EXEC = 2'b10;

  // A zero-length drain still needs a 1-bit register to keep widths legal.
  function automatic int drainCntWidth(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset (count_o -> 0)
//   inc        : add one this cycle unless already all-ones
//   clear      : synchronous clear, wins over inc
//   count_o    : current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else if (clear) begin
      count_o <= '0;
    end else if (inc && !(&count_o)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard and flow controller for the F/D/E/M/W core. Turns decode, execute
// and memory status into per-stage stall/flush controls and a fetch redirect
// select, drains the back end for serializing instructions and parks the
// core after EBREAK. Also counts front-end stall cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal flow; serializing instruction in E starts a drain
// DRAIN | front end held, bubbles into E, waiting drainCnt cycles
// HALT  | parked after EBREAK until resume_i (memory idle)
//
// Ports:
//   clk_i, reset_n_i            : clock, asynchronous active-low reset
//   D_dataHazard_i, D_predictPC_i : decode hazard / predicted redirect
//   E_mispredict_i, E_serialize_i, E_isEBREAK_i, E_mcBusy_i : execute status
//   M_memBusy_i                 : data memory access still outstanding
//   resume_i                    : debug resume, used only in HALT
//   F/D/E/M_stall_o             : hold stage pipeline register
//   D/E/M_flush_o               : kill / bubble the stage input
//   redirect_o                  : 00 sequential, 01 D prediction, 10 E correction
//   halted_o                    : core parked in HALT
//   stallCycles_o               : saturating count of cycles with F_stall_o=1
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_BITS     = 32
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                D_dataHazard_i,
  input  logic                D_predictPC_i,
  input  logic                E_mispredict_i,
  input  logic                E_serialize_i,
  input  logic                E_isEBREAK_i,
  input  logic                E_mcBusy_i,
  input  logic                M_memBusy_i,
  input  logic                resume_i,
  output logic                F_stall_o,
  output logic                D_stall_o,
  output logic                E_stall_o,
  output logic                M_stall_o,
  output logic                D_flush_o,
  output logic                E_flush_o,
  output logic                M_flush_o,
  output logic [1:0]          redirect_o,
  output logic                halted_o,
  output logic [CNT_BITS-1:0] stallCycles_o
);

  localparam int             DCW        = drainCntWidth(DRAIN_CYCLES);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

  seqState_t      state, stateNext;
  logic [DCW-1:0] drainCnt, drainCntNext;
  logic           ebreakPend, ebreakPendNext;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= RUN;
      drainCnt   <= '0;
      ebreakPend <= 1'b0;
    end else begin
      state      <= stateNext;
      drainCnt   <= drainCntNext;
      ebreakPend <= ebreakPendNext;
    end
  end

  always_comb begin
    F_stall_o      = 1'b0;
    D_stall_o      = 1'b0;
    E_stall_o      = 1'b0;
    M_stall_o      = 1'b0;
    D_flush_o      = 1'b0;
    E_flush_o      = 1'b0;
    M_flush_o      = 1'b0;
    redirect_o     = REDIR_SEQ;
    stateNext      = state;
    drainCntNext   = drainCnt;
    ebreakPendNext = ebreakPend;

    if (M_memBusy_i) begin
      // Whole pipe frozen; sequencing state is held so a busy cycle
      // lengthens a drain by exactly one cycle.
      F_stall_o = 1'b1;
      D_stall_o = 1'b1;
      E_stall_o = 1'b1;
      M_stall_o = 1'b1;
    end else begin
      if (E_mcBusy_i) begin
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        E_stall_o = 1'b1;
        M_flush_o = 1'b1;
      end else if (E_mispredict_i && (state == RUN)) begin
        D_flush_o  = 1'b1;
        E_flush_o  = 1'b1;
        redirect_o = REDIR_EXEC;
      end else if (state != RUN) begin
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        E_flush_o = 1'b1;
      end else if (E_serialize_i || E_isEBREAK_i) begin
        F_stall_o      = 1'b1;
        D_stall_o      = 1'b1;
        E_flush_o      = 1'b1;
        ebreakPendNext = E_isEBREAK_i;
        if (DRAIN_CYCLES == 0) begin
          stateNext = E_isEBREAK_i ? HALT : RUN;
        end else begin
          stateNext    = DRAIN;
          drainCntNext = DRAIN_LOAD;
        end
      end else if (D_dataHazard_i) begin
        // Prediction from the stalled D instruction is dropped here and
        // simply re-requested once the hazard clears.
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        E_flush_o = 1'b1;
      end else if (D_predictPC_i) begin
        D_flush_o  = 1'b1;
        redirect_o = REDIR_PRED;
      end

      case (state)
        DRAIN: begin
          if (drainCnt <= DCW'(1)) begin
            drainCntNext = '0;
            stateNext    = ebreakPend ? HALT : RUN;
          end else begin
            drainCntNext = drainCnt - DCW'(1);
          end
        end
        HALT: begin
          if (resume_i) begin
            stateNext      = RUN;
            ebreakPendNext = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted_o = (state == HALT);

  sat_counter #(
    .WIDTH(CNT_BITS)
  ) uStallCnt (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc      (F_stall_o),
    .clear    (1'b0),
    .count_o  (stallCycles_o)
  );

endmodule
